mcycle_muldiv: RTL

- Iterative multi-cycle multiply/divide unit for the RV32M extension, placed in the Execute stage beside the ALU.
- It produces the Busy signal that the hazard unit uses to stall Fetch and Decode. It is the source end of that stall interface.
- One operation runs at a time. Result is valid in the single cycle in which Busy drops.

---
 rtl/mcycle_muldiv.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mcycle_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with the sign fix-up applied on the last iteration.
module mcycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [2:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   result_q, result_d;

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    logic signed [WIDTH-1:0] op1_s, op2_s;
    logic                    is_div, signed1, signed2, sign1, sign2;
    logic [WIDTH-1:0]        mag1, mag2;
    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      mul_next, mul_fix, div_next;
    logic                    div_fits;
    logic [WIDTH-1:0]        div_sub;
    logic [WIDTH-1:0]        final_res;

    assign op1_s = Operand1;
    assign op2_s = Operand2;

    // Operand decode for the instruction waiting in Execute
    always_comb begin
        is_div  = MCycleOp[2];
        signed1 = (MCycleOp == OP_MULH) || (MCycleOp == OP_MULHSU) ||
                  (MCycleOp == OP_DIV)  || (MCycleOp == OP_REM);
        signed2 = (MCycleOp == OP_MULH) || (MCycleOp == OP_DIV) || (MCycleOp == OP_REM);
        sign1   = signed1 && (op1_s < 0);
        sign2   = signed2 && (op2_s < 0);
        mag1    = cneg_w(Operand1, sign1);
        mag2    = cneg_w(Operand2, sign2);
    end

    // One iteration of each core; prod_q holds {acc, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{prod_q[0]}}};
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
        mul_fix  = cneg_2w(mul_next, neg_q);
        div_fits = prod_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q};
        div_sub  = prod_q[2*WIDTH-2:WIDTH-1] - b_q;
        div_next = div_fits ? {div_sub, prod_q[WIDTH-2:0], 1'b1}
                            : {prod_q[2*WIDTH-2:0], 1'b0};
        case (op_q)
            OP_MUL:                      final_res = mul_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = mul_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             final_res = cneg_w(div_next[WIDTH-1:0], neg_q);
            default:                     final_res = cneg_w(div_next[2*WIDTH-1:WIDTH], neg_q);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        b_d      = b_q;
        prod_d   = prod_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d    = MCycleOp;
                    count_d = '0;
                    if (is_div && (Operand2 == '0)) begin
                        result_d = MCycleOp[1] ? Operand1 : '1;
                        state_d  = DONE;
                    end else if (((MCycleOp == OP_DIV) || (MCycleOp == OP_REM)) &&
                                 (Operand1 == MIN_NEG) && (Operand2 == '1)) begin
                        result_d = MCycleOp[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        // REM takes the dividend's sign; everything else the XOR of both
                        neg_d   = (MCycleOp == OP_REM) ? sign1 : (sign1 ^ sign2);
                        b_d     = is_div ? mag2 : mag1;
                        prod_d  = {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                count_d = count_q + CW'(1);
                prod_d  = op_q[2] ? div_next : mul_next;
                if (count_q == LAST_CNT) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            result_q <= result_d;
        end
    end

    // Stall drops the moment reset is asserted, even if Start is still high
    assign Busy   = RESETn & (((state_q == IDLE) & Start) | (state_q == RUN));
    assign Result = result_q;

endmodule
